// File: rtl/ir_tx_encoder.sv
// NEC-style IR transmit encoder: one byte in, leader + {~data, data} LSB first + stop mark + gap.
// Define IR_TX_CARRIER_EN to modulate marks with the on-chip carrier; otherwise marks are a raw envelope.
module ir_tx_encoder #(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned GAP_UNITS    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ir_led
);

  localparam int unsigned UnitW    = $clog2(UNIT_CYCLES);
  localparam int unsigned MaxUnits = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int unsigned NumW     = $clog2(MaxUnits);

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [UnitW-1:0] unit_cnt_q, unit_cnt_d;
  logic [NumW-1:0]  unit_num_q, unit_num_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic             done_q, done_d;
  logic             led_q, led_d;

  logic            unit_last;
  logic [NumW-1:0] units_last;
  logic            state_end;
  logic            mark;

  always_comb begin
    unit_last = (unit_cnt_q == UnitW'(UNIT_CYCLES - 1));
    unique case (state_q)
      StLeadMark:  units_last = NumW'(15);
      StLeadSpace: units_last = NumW'(7);
      StBitSpace:  units_last = shift_q[0] ? NumW'(2) : NumW'(0);
      StGap:       units_last = NumW'(GAP_UNITS - 1);
      default:     units_last = NumW'(0);
    endcase
    state_end = unit_last && (unit_num_q == units_last);
    mark      = (state_q == StLeadMark) || (state_q == StBitMark) || (state_q == StStopMark);
  end

  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    unit_num_d = unit_num_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    if (state_q == StIdle) begin
      if (tx_valid) begin
        state_d    = StLeadMark;
        shift_d    = {~tx_data, tx_data};
        unit_cnt_d = '0;
        unit_num_d = '0;
        bit_cnt_d  = '0;
      end
    end else begin
      unit_cnt_d = unit_last ? '0 : unit_cnt_q + UnitW'(1);
      if (unit_last) begin
        unit_num_d = unit_num_q + NumW'(1);
      end
      if (state_end) begin
        unit_num_d = '0;
        unique case (state_q)
          StLeadMark:  state_d = StLeadSpace;
          StLeadSpace: state_d = StBitMark;
          StBitMark:   state_d = StBitSpace;
          StBitSpace: begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = (bit_cnt_q == 4'd15) ? StStopMark : StBitMark;
          end
          StStopMark: begin
            state_d = StGap;
            done_d  = 1'b1;
          end
          StGap:       state_d = StIdle;
          default:     state_d = StIdle;
        endcase
      end
    end
  end

`ifdef IR_TX_CARRIER_EN
  localparam int unsigned CarrW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CarrW-1:0] carr_cnt_q, carr_cnt_d;
  logic             carr_ph_q, carr_ph_d;
  logic             mark_next;

  always_comb begin
    mark_next  = (state_d == StLeadMark) || (state_d == StBitMark) || (state_d == StStopMark);
    carr_cnt_d = carr_cnt_q;
    carr_ph_d  = carr_ph_q;
    // Marks never follow marks, so entering one always restarts the carrier high.
    if (mark_next && !mark) begin
      carr_cnt_d = '0;
      carr_ph_d  = 1'b1;
    end else if (mark) begin
      if (carr_cnt_q == CarrW'(CARRIER_HALF - 1)) begin
        carr_cnt_d = '0;
        carr_ph_d  = ~carr_ph_q;
      end else begin
        carr_cnt_d = carr_cnt_q + CarrW'(1);
      end
    end
    led_d = mark && !state_end && carr_ph_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carr_cnt_q <= '0;
      carr_ph_q  <= 1'b0;
    end else begin
      carr_cnt_q <= carr_cnt_d;
      carr_ph_q  <= carr_ph_d;
    end
  end
`else
  always_comb begin
    led_d = mark;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      unit_cnt_q <= '0;
      unit_num_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      unit_num_q <= unit_num_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign tx_ready = (state_q == StIdle);
  assign busy     = ~tx_ready;
  assign done     = done_q;
  assign ir_led   = led_q;

endmodule

// File: tb/tb_ir_tx_encoder.sv
// Scoreboard bench for ir_tx_encoder with UNIT_CYCLES=4, CARRIER_HALF=1, GAP_UNITS=2.
module tb_ir_tx_encoder;

  localparam int FrameCycles = 292;
  localparam int GapCycles   = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ir_led;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frames_seen = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t sb_q[$];
  logic wave[512];

  ir_tx_encoder #(
    .UNIT_CYCLES (4),
    .CARRIER_HALF(1),
    .GAP_UNITS   (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .done    (done),
    .ir_led  (ir_led)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Position inside the current mark for cycle k after the leader starts, or -1 in a space.
  function automatic int mark_idx(input logic [7:0] d, input int k);
    logic [15:0] w;
    int p;
    w = {~d, d};
    p = k;
    if (p < 64) return p;
    p -= 64;
    if (p < 32) return -1;
    p -= 32;
    for (int i = 0; i < 16; i++) begin
      if (p < 4) return p;
      p -= 4;
      if (w[i]) begin
        if (p < 12) return -1;
        p -= 12;
      end else begin
        if (p < 4) return -1;
        p -= 4;
      end
    end
    if (p < 4) return p;
    return -1;
  endfunction

  function automatic logic exp_led(input logic [7:0] d, input int k);
    int m;
    m = mark_idx(d, k);
    if (m < 0) return 1'b0;
`ifdef IR_TX_CARRIER_EN
    return (m % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: records the LED waveform and checks each frame when done is presented.
  initial begin
    logic done_prev;
    int   gap_d;
    int   bad;
    exp_t e;
    done_prev = 1'b0;
    gap_d     = -100;
    forever begin
      @(negedge clock);
      wave[cyc % 512] = ir_led;
      if (reset) begin
        done_prev = 1'b0;
        gap_d     = -100;
        continue;
      end
      if (done) begin
        chk("done_single_cycle", int'(done_prev), 0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got a done pulse, expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          frames_seen++;
          chk("accept_to_done", cyc - e.acc, FrameCycles);
          chk("led_low_at_accept", int'(wave[e.acc % 512]), 0);
          bad = -1;
          for (int k = 0; k < FrameCycles; k++) begin
            if (bad < 0 && wave[(e.acc + 1 + k) % 512] !== exp_led(e.data, k)) bad = k;
          end
          chk($sformatf("frame_%02h_first_bad_cycle", e.data), bad, -1);
          gap_d = cyc;
        end
      end
      done_prev = done;
      if (cyc == gap_d + GapCycles - 1) begin
        chk("gap_ready_low", int'(tx_ready), 0);
        chk("gap_busy_high", int'(busy), 1);
      end
      if (cyc == gap_d + GapCycles) begin
        chk("ready_after_gap", int'(tx_ready), 1);
        chk("busy_after_gap", int'(busy), 0);
        bad = 0;
        for (int k = 1; k <= GapCycles; k++) bad |= int'(wave[(gap_d + k) % 512]);
        chk("gap_led_zero", bad, 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, output int acc);
    @(negedge clock);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    acc      = cyc;
    tx_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int acc1;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_led", int'(ir_led), 0);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-leader: abandoned, no done, no scoreboard entry.
    send(8'h11, acc);
    repeat (20) @(posedge clock);
    #1;
    chk("leader_led_before_reset", int'(ir_led), 1);
    chk("leader_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_led", int'(ir_led), 0);
    chk("async_reset_ready", int'(tx_ready), 1);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (320) @(posedge clock);

    send(8'h00, acc);
    sb_q.push_back('{data: 8'h00, acc: acc});
    repeat (310) @(posedge clock);

    send(8'hA5, acc);
    sb_q.push_back('{data: 8'hA5, acc: acc});
    repeat (310) @(posedge clock);

    // tx_valid held: second byte taken on the first IDLE cycle after the gap.
    @(negedge clock);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    acc1    = cyc;
    tx_data = 8'hC3;
    sb_q.push_back('{data: 8'h3C, acc: acc1});
    sb_q.push_back('{data: 8'hC3, acc: acc1 + FrameCycles + GapCycles + 1});
    repeat (350) @(posedge clock);
    #1;
    tx_valid = 1'b0;
    repeat (300) @(posedge clock);

    // Request while busy must be dropped.
    send(8'h5A, acc);
    sb_q.push_back('{data: 8'h5A, acc: acc});
    repeat (100) @(posedge clock);
    @(negedge clock);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    repeat (2) @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (520) @(posedge clock);
    #1;

    chk("scoreboard_empty", sb_q.size(), 0);
    chk("frames_seen", frames_seen, 5);
    chk("final_ready", int'(tx_ready), 1);
    chk("final_led", int'(ir_led), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
